// File: rtl/pzcorebus_response_1_to_m_switch_if.sv
// Response-routing bundle between the 1:M response switch and its environment.
// o_drop exists only when PZCOREBUS_RESPONSE_SWITCH_DROP_EN is defined.
interface pzcorebus_response_1_to_m_switch_if #(
  parameter int SLAVES        = 2,
  parameter int DEPTH         = 4,
  parameter int PAYLOAD_WIDTH = 64
);
  logic                       i_select_valid;
  logic                       o_select_ready;
  logic [SLAVES-1:0]          i_select;
  logic                       i_resp_valid;
  logic                       o_resp_accept;
  logic                       i_resp_last;
  logic [PAYLOAD_WIDTH-1:0]   i_resp_payload;
  logic [SLAVES-1:0]          o_resp_valid;
  logic [SLAVES-1:0]          i_resp_accept;
  logic                       o_resp_last;
  logic [PAYLOAD_WIDTH-1:0]   o_resp_payload;
  logic                       o_response_ack;
  logic [$clog2(DEPTH+1)-1:0] o_outstanding;
`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
  logic                       o_drop;
`endif

  // The switch itself.
  modport slave (
    input  i_select_valid, i_select, i_resp_valid, i_resp_last, i_resp_payload, i_resp_accept,
    output o_select_ready, o_resp_accept, o_resp_valid, o_resp_last, o_resp_payload,
    output o_response_ack, o_outstanding
`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
   ,output o_drop
`endif
  );

  // The command side, upstream response source and downstream ports.
  modport master (
    output i_select_valid, i_select, i_resp_valid, i_resp_last, i_resp_payload, i_resp_accept,
    input  o_select_ready, o_resp_accept, o_resp_valid, o_resp_last, o_resp_payload,
    input  o_response_ack, o_outstanding
`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
   ,input  o_drop
`endif
  );
endinterface

// File: rtl/pzcorebus_response_1_to_m_switch.sv
// Routes upstream response bursts to the slave recorded for each non-posted command, in order.
// Optional zero-select drop path compiled in with PZCOREBUS_RESPONSE_SWITCH_DROP_EN.
module pzcorebus_response_1_to_m_switch #(
  parameter int SLAVES        = 2,
  parameter int DEPTH         = 4,
  parameter int PAYLOAD_WIDTH = 64
) (
  input logic                               i_clk,
  input logic                               i_rst,
  pzcorebus_response_1_to_m_switch_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [SLAVES-1:0]        mem_q [DEPTH];
  logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     ack_q, ack_d;
  logic                     out_of_reset_q, out_of_reset_d;

  logic                     full, empty, push, pop, beat_fire;
  logic                     select_ready, resp_accept;
  logic [SLAVES-1:0]        head, resp_valid;
  logic [PAYLOAD_WIDTH-1:0] payload;
`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
  logic                     head_zero, drop;
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path can infer a latch.
  always_comb begin
    full         = (count_q == CW'(DEPTH));
    empty        = (count_q == '0);
    head         = mem_q[rd_ptr_q];
    // Ready stays low until the first edge after reset releases.
    select_ready = out_of_reset_q && !full;
    push         = bus.i_select_valid && select_ready;

    resp_valid   = '0;
    resp_accept  = 1'b0;
    if (!empty) begin
      resp_valid  = {SLAVES{bus.i_resp_valid}} & head;
      resp_accept = |(head & bus.i_resp_accept);
    end

`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
    // An all-zero routing entry swallows its burst instead of stalling.
    head_zero = !empty && (head == '0);
    drop      = head_zero && bus.i_resp_valid;
    if (head_zero) resp_accept = 1'b1;
`endif

    beat_fire      = bus.i_resp_valid && resp_accept;
    pop            = beat_fire && bus.i_resp_last;

    wr_ptr_d       = wr_ptr_q + AW'(push);
    rd_ptr_d       = rd_ptr_q + AW'(pop);
    count_d        = count_q + CW'(push) - CW'(pop);
    ack_d          = pop;
    out_of_reset_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      ack_q          <= 1'b0;
      out_of_reset_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      ack_q          <= ack_d;
      out_of_reset_q <= out_of_reset_d;
    end
  end

  // NOTE: the storage array has no reset; entries only become visible through the pointers.
  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.i_select;
  end

  assign payload            = bus.i_resp_payload;
  assign bus.o_select_ready = select_ready;
  assign bus.o_resp_accept  = resp_accept;
  assign bus.o_resp_valid   = resp_valid;
  assign bus.o_resp_last    = bus.i_resp_last;
  assign bus.o_resp_payload = payload;
  assign bus.o_response_ack = ack_q;
  assign bus.o_outstanding  = count_q;
`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
  assign bus.o_drop         = drop;
`endif
endmodule

// File: tb/tb_pzcorebus_response_1_to_m_switch.sv
// Scoreboard bench for the 1:M response switch: expected beats queued at drive time, popped on accept.
module tb_pzcorebus_response_1_to_m_switch;
  localparam int SLAVES = 4;
  localparam int DEPTH  = 4;
  localparam int PW     = 64;

  typedef struct {
    logic [SLAVES-1:0] sel;
    logic [PW-1:0]     payload;
    logic              last;
  } beat_t;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  beat_t sb_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    ack_cnt  = 0;
  int    drop_cnt = 0;
  logic  exp_ack  = 1'b0;

  always #5 clk = ~clk;

  pzcorebus_response_1_to_m_switch_if #(.SLAVES(SLAVES), .DEPTH(DEPTH), .PAYLOAD_WIDTH(PW)) bus ();

  pzcorebus_response_1_to_m_switch #(.SLAVES(SLAVES), .DEPTH(DEPTH), .PAYLOAD_WIDTH(PW)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Ack must follow each accepted last beat by exactly one cycle; accepted beats match the queue.
  always @(negedge clk) begin : monitor
    beat_t e;
    if (rst) begin
      exp_ack = 1'b0;
    end else begin
      check("ack_timing", 64'(bus.o_response_ack), 64'(exp_ack));
      check("valid_onehot0", 64'($onehot0(bus.o_resp_valid)), 64'd1);
      if (bus.o_response_ack) ack_cnt++;
`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
      if (bus.o_drop) drop_cnt++;
`endif
      exp_ack = bus.i_resp_valid && bus.o_resp_accept && bus.i_resp_last;
      if (bus.i_resp_valid && bus.o_resp_accept) begin
        if (sb_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          check("beat_route", 64'(bus.o_resp_valid), 64'(e.sel));
          check("beat_payload", bus.o_resp_payload, e.payload);
          check("beat_last", 64'(bus.o_resp_last), 64'(e.last));
`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
          check("beat_drop", 64'(bus.o_drop), 64'(e.sel == '0));
`endif
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_beat(input logic [SLAVES-1:0] sel, input logic [PW-1:0] pl, input logic last);
    bus.i_resp_valid   = 1'b1;
    bus.i_resp_payload = pl;
    bus.i_resp_last    = last;
    sb_q.push_back('{sel, pl, last});
  endtask

  task automatic idle_resp();
    bus.i_resp_valid = 1'b0;
    bus.i_resp_last  = 1'b0;
  endtask

  task automatic wait_accept(input string tag, input bit rand_bp);
    bit done = 1'b0;
    for (int k = 0; k < 64 && !done; k++) begin
      if (rand_bp) bus.i_resp_accept = SLAVES'($urandom);
      @(negedge clk);
      done = bus.o_resp_accept;
      tick();
    end
    if (!done) check({tag, "_timeout"}, 64'd0, 64'd1);
  endtask

  task automatic push_entry(input logic [SLAVES-1:0] sel);
    bit done = 1'b0;
    bus.i_select_valid = 1'b1;
    bus.i_select       = sel;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      done = bus.o_select_ready;
      tick();
    end
    if (!done) check("push_timeout", 64'd0, 64'd1);
    bus.i_select_valid = 1'b0;
  endtask

  task automatic send_burst(input logic [SLAVES-1:0] sel, input int n, input logic [PW-1:0] base,
                            input bit rand_bp);
    for (int i = 0; i < n; i++) begin
      drive_beat(sel, base + PW'(i), i == n - 1);
      wait_accept("burst", rand_bp);
    end
    idle_resp();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [SLAVES-1:0] rsel [3];
    int                ack_before;

    bus.i_select_valid = 1'b0;
    bus.i_select       = '0;
    bus.i_resp_valid   = 1'b1;
    bus.i_resp_last    = 1'b0;
    bus.i_resp_payload = '0;
    bus.i_resp_accept  = '1;

    // Reset state, with a beat offered during reset.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_select_ready", 64'(bus.o_select_ready), 64'd0);
    check("rst_resp_accept", 64'(bus.o_resp_accept), 64'd0);
    check("rst_resp_valid", 64'(bus.o_resp_valid), 64'd0);
    check("rst_outstanding", 64'(bus.o_outstanding), 64'd0);
    check("rst_ack", 64'(bus.o_response_ack), 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_resp();
    tick();
    @(negedge clk);
    check("ready_after_reset", 64'(bus.o_select_ready), 64'd1);
    tick();

    // Empty FIFO blocks beats; pushed entry routes from the next cycle; 3-beat burst to port 2.
    drive_beat(4'b0100, 64'hA0, 1'b0);
    @(negedge clk);
    check("empty_accept", 64'(bus.o_resp_accept), 64'd0);
    check("empty_valid", 64'(bus.o_resp_valid), 64'd0);
    tick();
    bus.i_select_valid = 1'b1;
    bus.i_select       = 4'b0100;
    @(negedge clk);
    check("no_bypass_accept", 64'(bus.o_resp_accept), 64'd0);
    tick();
    bus.i_select_valid = 1'b0;
    @(negedge clk);
    check("first_accept", 64'(bus.o_resp_accept), 64'd1);
    check("first_valid", 64'(bus.o_resp_valid), 64'b0100);
    check("single_outstanding_1", 64'(bus.o_outstanding), 64'd1);
    tick();
    drive_beat(4'b0100, 64'hA1, 1'b0);
    wait_accept("single_b1", 1'b0);
    drive_beat(4'b0100, 64'hA2, 1'b1);
    wait_accept("single_b2", 1'b0);
    idle_resp();
    @(negedge clk);
    check("single_ack", 64'(bus.o_response_ack), 64'd1);
    check("single_outstanding_0", 64'(bus.o_outstanding), 64'd0);
    tick();

    // Ordering under backpressure: port 0 stalls, port 3 must not see its burst early.
    push_entry(4'b0001);
    push_entry(4'b1000);
    bus.i_resp_accept = 4'b1110;
    drive_beat(4'b0001, 64'hB0, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("bp_no_accept", 64'(bus.o_resp_accept), 64'd0);
      check("bp_valid_port0", 64'(bus.o_resp_valid), 64'b0001);
      tick();
    end
    bus.i_resp_accept = '1;
    wait_accept("bp_b0", 1'b0);
    drive_beat(4'b0001, 64'hB1, 1'b1);
    wait_accept("bp_b1", 1'b0);
    send_burst(4'b1000, 2, 64'hB8, 1'b0);
    @(negedge clk);
    check("bp_outstanding_0", 64'(bus.o_outstanding), 64'd0);
    tick();

    // Full boundary: four pushes fill, fifth held until a pop frees a slot.
    bus.i_select_valid = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      bus.i_select = SLAVES'(1 << i);
      @(negedge clk);
      check("fill_ready", 64'(bus.o_select_ready), 64'd1);
      check("fill_count", 64'(bus.o_outstanding), 64'(i));
      tick();
    end
    bus.i_select = 4'b0010;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("full_ready", 64'(bus.o_select_ready), 64'd0);
      check("full_count", 64'(bus.o_outstanding), 64'd4);
      tick();
    end
    drive_beat(4'b0001, 64'hC0, 1'b1);
    @(negedge clk);
    check("full_pop_ready", 64'(bus.o_select_ready), 64'd0);
    check("full_pop_accept", 64'(bus.o_resp_accept), 64'd1);
    tick();
    idle_resp();
    @(negedge clk);
    check("after_pop_count", 64'(bus.o_outstanding), 64'd3);
    check("after_pop_ready", 64'(bus.o_select_ready), 64'd1);
    tick();
    bus.i_select_valid = 1'b0;
    @(negedge clk);
    check("refill_count", 64'(bus.o_outstanding), 64'd4);
    tick();
    send_burst(4'b0010, 1, 64'hC1, 1'b0);
    send_burst(4'b0100, 2, 64'hC2, 1'b0);
    send_burst(4'b1000, 1, 64'hC4, 1'b0);
    send_burst(4'b0010, 1, 64'hC5, 1'b0);
    @(negedge clk);
    check("drain_count", 64'(bus.o_outstanding), 64'd0);
    tick();

    // Random routing with random per-port backpressure.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 3; i++) begin
        rsel[i] = SLAVES'(1 << $urandom_range(0, SLAVES - 1));
        push_entry(rsel[i]);
      end
      for (int i = 0; i < 3; i++)
        send_burst(rsel[i], int'($urandom_range(1, 3)), PW'(64'h100 * (r * 3 + i + 1)), 1'b1);
    end
    bus.i_resp_accept = '1;
    tick();

    // Reset mid-burst with two entries queued.
    push_entry(4'b0010);
    push_entry(4'b0100);
    ack_before = ack_cnt;
    drive_beat(4'b0010, 64'hD0, 1'b0);
    wait_accept("rst_mid_b0", 1'b0);
    bus.i_resp_valid   = 1'b1;
    bus.i_resp_payload = 64'hD1;
    bus.i_resp_last    = 1'b0;
    rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    check("midrst_outstanding", 64'(bus.o_outstanding), 64'd0);
    check("midrst_accept", 64'(bus.o_resp_accept), 64'd0);
    check("midrst_ready", 64'(bus.o_select_ready), 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("postrst_accept", 64'(bus.o_resp_accept), 64'd0);
      check("postrst_valid", 64'(bus.o_resp_valid), 64'd0);
      check("postrst_outstanding", 64'(bus.o_outstanding), 64'd0);
      tick();
    end
    check("postrst_no_ack", 64'(ack_cnt), 64'(ack_before));
    sb_q.push_back('{4'b0010, 64'hD1, 1'b0});
    push_entry(4'b0010);
    wait_accept("postrst_b1", 1'b0);
    drive_beat(4'b0010, 64'hD2, 1'b1);
    wait_accept("postrst_b2", 1'b0);
    idle_resp();
    tick();

`ifdef PZCOREBUS_RESPONSE_SWITCH_DROP_EN
    // Zero routing entry: burst is swallowed, drop pulses per beat, one ack.
    push_entry(4'b0000);
    ack_before        = ack_cnt;
    drop_cnt          = 0;
    bus.i_resp_accept = '0;
    send_burst(4'b0000, 2, 64'hE0, 1'b0);
    tick();
    tick();
    check("drop_cycles", 64'(drop_cnt), 64'd2);
    check("drop_ack_once", 64'(ack_cnt - ack_before), 64'd1);
    check("drop_outstanding", 64'(bus.o_outstanding), 64'd0);
    bus.i_resp_accept = '1;
`else
    // Zero routing entry stalls indefinitely; reset clears it.
    push_entry(4'b0000);
    bus.i_resp_valid   = 1'b1;
    bus.i_resp_last    = 1'b1;
    bus.i_resp_payload = 64'hE0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("zero_stall_accept", 64'(bus.o_resp_accept), 64'd0);
      check("zero_stall_valid", 64'(bus.o_resp_valid), 64'd0);
      check("zero_stall_outstanding", 64'(bus.o_outstanding), 64'd1);
      tick();
    end
    rst = 1'b1;
    idle_resp();
    tick();
    rst = 1'b0;
    tick();
    tick();
`endif

    @(negedge clk);
    check("final_outstanding", 64'(bus.o_outstanding), 64'd0);
    check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/pzcorebus_response_1_to_m_switch.md
PZCOREBUS_RESPONSE_1_TO_M_SWITCH -- requirements
Module: pzcorebus_response_1_to_m_switch

Interface
REQ-001 SHALL have parameter SLAVES, default 2: number of downstream response ports, 2..16.
REQ-002 SHALL have parameter DEPTH, default 4: routing-FIFO entries, power of 2, at least 2.
REQ-003 SHALL have parameter PAYLOAD_WIDTH, default 64: width of the response payload (sresp, sid, sinfo, sdata packed).
REQ-004 SHALL have ports:
  i_clk  input  1  sole clock; all logic on its rising edge.
  i_rst  input  1  asynchronous, active-high reset.
  i_select_valid  input  1  routing entry offered; pulses on each non-posted command accept.
  o_select_ready  output  1  routing FIFO can accept an entry.
  i_select  input  SLAVES  one-hot slave that issued the non-posted command.
  i_resp_valid  input  1  upstream response beat valid.
  o_resp_accept  output  1  upstream response beat accepted.
  i_resp_last  input  1  final beat of a response burst.
  i_resp_payload  input  PAYLOAD_WIDTH  response beat payload.
  o_resp_valid  output  SLAVES  per-port response valid.
  i_resp_accept  input  SLAVES  per-port response accept.
  o_resp_last  output  1  broadcast copy of i_resp_last.
  o_resp_payload  output  PAYLOAD_WIDTH  broadcast copy of i_resp_payload.
  o_response_ack  output  1  one-cycle pulse when a burst's last beat is accepted.
  o_outstanding  output  $clog2(DEPTH+1)  number of routing entries held.
  o_drop  output  1  beat discarded (exists only with the macro in REQ-019).

Function
REQ-005 SHALL hold routing entries in a FIFO of DEPTH entries, SLAVES bits wide, using wrap-around read and write pointers.
REQ-006 SHALL drive o_select_ready = !full; the push rule is:
  - A push occurs when i_select_valid && o_select_ready.
  - When full, no push occurs, even if a pop happens in the same cycle.
REQ-007 SHALL register a pushed entry before it can route: an entry written at edge N routes beats from cycle N+1 onward, with no same-cycle bypass.
REQ-008 SHALL, with the FIFO empty, hold o_resp_accept=0 and o_resp_valid=0 whatever the value of i_resp_valid.
REQ-009 SHALL, with the FIFO non-empty and head entry H, drive o_resp_valid = {SLAVES{i_resp_valid}} & H and o_resp_accept = |(H & i_resp_accept).
REQ-010 SHALL drive o_resp_payload and o_resp_last combinationally from the inputs, with zero latency.
REQ-011 SHALL pop the head entry only on an accepted beat with i_resp_last=1; it shall not pop on non-last beats.
REQ-012 SHALL assert o_response_ack as a registered pulse exactly one cycle after each pop.
REQ-013 SHALL update o_outstanding by push minus pop; a simultaneous push and pop leaves it unchanged.
REQ-014 SHALL NOT generate any beat on a port whose head bit is 0, and o_resp_valid shall be at most one-hot.

Reset
REQ-015 SHALL, while i_rst=1, asynchronously clear both pointers, o_outstanding, o_response_ack and o_drop.
REQ-016 SHALL, during reset, drive o_select_ready=0, o_resp_accept=0 and o_resp_valid=0; o_select_ready rises the first cycle after i_rst falls.
REQ-017 SHALL discard all queued entries on a reset asserted mid-burst; the remaining beats stall until a new entry is pushed.
REQ-018 SHALL leave the FIFO storage array unreset; only the pointers make it valid.

Configuration
REQ-019 SHALL compile in a zero-select drop path when macro PZCOREBUS_RESPONSE_SWITCH_DROP_EN is defined:
  - A head entry of all zeros accepts beats (o_resp_accept=1 when i_resp_valid) and forwards none.
  - o_drop pulses combinationally for each such beat.
  - A last beat pops the entry and still produces o_response_ack.
REQ-020 SHALL behave as follows when PZCOREBUS_RESPONSE_SWITCH_DROP_EN is not defined:
  - The o_drop port is absent.
  - A zero head entry stalls indefinitely (o_resp_accept=0).

Verification
REQ-021 SHALL cover single routing: SLAVES=4, push 4'b0100, then a 3-beat burst with i_resp_accept=4'b1111 -> o_resp_valid=4'b0100 for 3 beats, o_response_ack one cycle after the last beat, o_outstanding 1->0.
REQ-022 SHALL cover ordering under backpressure: push 4'b0001 then 4'b1000, hold i_resp_accept[0]=0 for 5 cycles -> no accept for 5 cycles, and no beat ever reaches port 3 before port 0's last beat.
REQ-023 SHALL cover full boundary: DEPTH=4, 4 pushes -> o_select_ready=0; 5th push held; a simultaneous pop frees a slot and the push is accepted the following cycle; o_outstanding peaks at 4.
REQ-024 SHALL cover the empty case: i_resp_valid=1 with an empty FIFO -> o_resp_accept=0 and o_resp_valid=0; push at edge N -> first accept at cycle N+1.
REQ-025 SHALL cover reset mid-burst: i_rst pulsed after beat 1 of 3 with 2 entries queued -> o_outstanding=0, o_resp_accept=0, o_response_ack never pulses.
REQ-026 SHALL cover the macro: with PZCOREBUS_RESPONSE_SWITCH_DROP_EN, push 4'b0000 and a 2-beat burst -> o_drop high 2 cycles, o_resp_valid=0, o_response_ack pulses once.
